uart_mmio_periph: RTL and testbench

//  Memory-mapped UART peripheral on the CPU's MEM-stage bus (address bit 30 set = peripheral space).

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_mmio_periph.sv | 200 ++++++++++++++++++++
 tb/tb_uart_mmio_periph.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared register map, CON bit positions and FSM encodings for the MMIO UART.
`timescale 1ns/1ps
package uart_pkg;
    localparam logic [7:0] UART_TXD = 8'h18;
    localparam logic [7:0] UART_RXD = 8'h1C;
    localparam logic [7:0] UART_CON = 8'h20;

    localparam int CON_TX_IE   = 0;
    localparam int CON_RX_IE   = 1;
    localparam int CON_TX_DONE = 2;
    localparam int CON_RX_RDY  = 3;
    localparam int CON_TX_BUSY = 4;
    localparam int CON_OVR     = 5;
    localparam int CON_FERR    = 6;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_t;

    // Clocks per 16x oversample tick, truncated and never below 1.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / (baud * 16);
        return (d < 1) ? 1 : d;
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock oversample tick every DIV clocks.
`timescale 1ns/1ps
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == LAST);
            r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = r_tick;
endmodule

// File: rtl/uart_mmio_periph.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers, TX and RX FSMs, level irq.
`timescale 1ns/1ps
module uart_mmio_periph
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        tx,
    input  logic        rx
);
    localparam int DIV = calc_div(CLK_HZ, BAUD);

    logic w_tick;
    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    logic w_wr_txd, w_wr_con, w_rd_rxd, w_rd_con;
    assign w_wr_txd = wr && (addr[7:0] == UART_TXD);
    assign w_wr_con = wr && (addr[7:0] == UART_CON);
    assign w_rd_rxd = rd && (addr[7:0] == UART_RXD);
    assign w_rd_con = rd && (addr[7:0] == UART_CON);

    logic w_unused;
    assign w_unused = ^{addr[31:8], wdata[31:8]};

    // ---------------- TX ----------------
    tx_state_t   r_tx_st;
    logic        r_tx_pend;
    logic [3:0]  r_tx_tcnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_txd;
    logic        w_tx_end, w_tx_busy, w_tx_acc;

    assign w_tx_end  = w_tick && (r_tx_st == TX_STOP) && (r_tx_tcnt == 4'd15);
    assign w_tx_busy = (r_tx_st != TX_IDLE) || r_tx_pend;
    // A write landing on the cycle STOP finishes is taken as if TX were already idle.
    assign w_tx_acc  = w_wr_txd && (!w_tx_busy || w_tx_end);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_st   <= TX_IDLE;
            r_tx_pend <= 1'b0;
            r_tx_tcnt <= 4'd0;
            r_tx_bit  <= 3'd0;
            r_txd     <= 8'h00;
        end else begin
            if (w_tx_acc) begin
                r_txd     <= wdata[7:0];
                r_tx_pend <= 1'b1;
            end
            if (w_tick) begin
                if (r_tx_st == TX_IDLE) begin
                    if (r_tx_pend) begin
                        r_tx_st   <= TX_START;
                        r_tx_pend <= 1'b0;
                        r_tx_tcnt <= 4'd0;
                    end
                end else begin
                    r_tx_tcnt <= r_tx_tcnt + 4'd1;
                    if (r_tx_tcnt == 4'd15) begin
                        case (r_tx_st)
                            TX_START: begin
                                r_tx_st  <= TX_DATA;
                                r_tx_bit <= 3'd0;
                            end
                            TX_DATA: begin
                                r_tx_bit <= r_tx_bit + 3'd1;
                                if (r_tx_bit == 3'd7) r_tx_st <= TX_STOP;
                            end
                            default: r_tx_st <= TX_IDLE;
                        endcase
                    end
                end
            end
        end
    end

    assign tx = (r_tx_st == TX_START) ? 1'b0 :
                (r_tx_st == TX_DATA)  ? r_txd[r_tx_bit] : 1'b1;

    // ---------------- RX ----------------
    logic        r_rx_s1, r_rx_s2;
    rx_state_t   r_rx_st;
    logic [3:0]  r_rx_tcnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_sh;
    logic [7:0]  r_rxd;
    logic        w_rx_stop_smp, w_rx_load, w_rx_ferr;

    assign w_rx_stop_smp = w_tick && (r_rx_st == RX_STOP) && (r_rx_tcnt == 4'd15);
    assign w_rx_load     = w_rx_stop_smp && r_rx_s2;
    assign w_rx_ferr     = w_rx_stop_smp && !r_rx_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_st   <= RX_IDLE;
            r_rx_tcnt <= 4'd0;
            r_rx_bit  <= 3'd0;
            r_rx_sh   <= 8'h00;
            r_rxd     <= 8'h00;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            if (w_rx_load) r_rxd <= r_rx_sh;
            if (w_tick) begin
                case (r_rx_st)
                    RX_IDLE: if (!r_rx_s2) begin
                        r_rx_st   <= RX_START;
                        r_rx_tcnt <= 4'd0;
                    end
                    // Re-check the line half a bit in, then sample mid-bit from here on.
                    RX_START: begin
                        r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        if (r_rx_tcnt == 4'd7) begin
                            r_rx_tcnt <= 4'd0;
                            r_rx_bit  <= 3'd0;
                            r_rx_st   <= r_rx_s2 ? RX_IDLE : RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        if (r_rx_tcnt == 4'd15) begin
                            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                            r_rx_bit <= r_rx_bit + 3'd1;
                            if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        if (r_rx_tcnt == 4'd15) r_rx_st <= r_rx_s2 ? RX_IDLE : RX_WAIT;
                    end
                    RX_WAIT: if (r_rx_s2) r_rx_st <= RX_IDLE;
                    default: r_rx_st <= RX_IDLE;
                endcase
            end
        end
    end

    // ---------------- flags / irq ----------------
    logic r_tx_ie, r_rx_ie, r_tx_done, r_rx_rdy, r_ovr, r_ferr, r_irq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_ie   <= 1'b0;
            r_rx_ie   <= 1'b0;
            r_tx_done <= 1'b0;
            r_rx_rdy  <= 1'b0;
            r_ovr     <= 1'b0;
            r_ferr    <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr_con) begin
                r_tx_ie <= wdata[CON_TX_IE];
                r_rx_ie <= wdata[CON_RX_IE];
            end
            // Set beats clear-by-read when both land in the same cycle.
            r_tx_done <= w_tx_end ? 1'b1 : (w_rd_con ? 1'b0 : r_tx_done);
            r_rx_rdy  <= w_rx_load ? 1'b1 : (w_rd_rxd ? 1'b0 : r_rx_rdy);
            r_ovr     <= (w_rx_load && r_rx_rdy) ? 1'b1 : (w_rd_rxd ? 1'b0 : r_ovr);
            r_ferr    <= w_rx_ferr ? 1'b1 : (w_rd_con ? 1'b0 : r_ferr);
            r_irq     <= (r_tx_ie && r_tx_done) || (r_rx_ie && r_rx_rdy);
        end
    end

    assign irq = r_irq;

    always_comb begin
        rdata = 32'h0;
        if (rd) begin
            case (addr[7:0])
                UART_TXD: rdata = {24'h0, r_txd};
                UART_RXD: rdata = {24'h0, r_rxd};
                UART_CON: begin
                    rdata[CON_TX_IE]   = r_tx_ie;
                    rdata[CON_RX_IE]   = r_rx_ie;
                    rdata[CON_TX_DONE] = r_tx_done;
                    rdata[CON_RX_RDY]  = r_rx_rdy;
                    rdata[CON_TX_BUSY] = w_tx_busy;
                    rdata[CON_OVR]     = r_ovr;
                    rdata[CON_FERR]    = r_ferr;
                end
                default: rdata = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mmio_periph.sv
// Directed bench for uart_mmio_periph with byte scoreboards on the TX line and RXD reads.
`timescale 1ns/1ps
module tb_uart_mmio_periph;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd = 1'b0, wr = 1'b0, rx = 1'b1;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [31:0] rdata;
    logic        irq, tx;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    always #5 clk = ~clk;

    uart_mmio_periph #(.CLK_HZ(1_600_000), .BAUD(10_000)) dut (
        .clk   (clk),
        .reset (reset),
        .rd    (rd),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq),
        .tx    (tx),
        .rx    (rx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; addr = {24'h400000, a}; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        rd = 1'b1; addr = {24'h400000, a};
        #1 d = rdata;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        @(negedge clk);
        rx = 1'b0;
        cyc(160);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(160);
        end
        rx = stopb;
        cyc(160);
        rx = 1'b1;
        cyc(20);
    endtask

    task automatic wait_tx_low(input string tag);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(tx), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  got, exp_b;
        logic [9:0]  frame;

        // 1: reset state
        cyc(3);
        chk("rst_tx", 32'(tx), 32'h1);
        chk("rst_irq", 32'(irq), 32'h0);
        @(negedge clk); reset = 1'b1;
        bus_rd(UART_CON, d); chk("rst_con", d, 32'h0);

        // 2/3: transmit 0xA5, a write of 0x3C while busy must be dropped
        bus_wr(UART_CON, 32'h1);
        txq.push_back(8'hA5);
        bus_wr(UART_TXD, 32'hA5);
        wait_tx_low("tx_start_seen");
        cyc(80);
        frame = {1'b1, txq[0], 1'b0};
        got = 8'h00;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tx_bit%0d", i), 32'(tx), 32'(frame[i]));
            if (i >= 1 && i <= 8) got[i-1] = tx;
            if (i == 2) begin
                bus_wr(UART_TXD, 32'h3C);
                cyc(158);
            end else if (i == 4) begin
                bus_rd(UART_CON, d); chk("con_busy", d, 32'h11);
                cyc(158);
            end else if (i < 9) begin
                cyc(160);
            end
        end
        exp_b = txq.pop_front();
        chk("tx_byte", 32'(got), 32'(exp_b));
        cyc(120);
        chk("tx_done_irq", 32'(irq), 32'h1);
        bus_rd(UART_CON, d); chk("con_tx_done", d, 32'h05);
        chk("irq_hold_1clk", 32'(irq), 32'h1);
        @(negedge clk);
        chk("irq_drop", 32'(irq), 32'h0);
        bus_rd(UART_CON, d); chk("con_done_clr", d, 32'h01);

        // 4: receive 0x5A
        bus_wr(UART_CON, 32'h2);
        rxq.push_back(8'h5A);
        send_rx(8'h5A, 1'b1);
        chk("rx_irq", 32'(irq), 32'h1);
        bus_rd(UART_CON, d); chk("con_rx_rdy", d, 32'h0A);
        bus_rd(UART_RXD, d);
        exp_b = rxq.pop_front();
        chk("rxd_5a", d, {24'h0, exp_b});
        bus_rd(UART_CON, d); chk("con_rdy_clr", d, 32'h02);

        // 5: overrun keeps the newest byte; a short glitch is ignored
        rxq.push_back(8'h11);
        send_rx(8'h11, 1'b1);
        rxq.push_back(8'h22);
        send_rx(8'h22, 1'b1);
        bus_rd(UART_CON, d); chk("con_ovr", d, 32'h2A);
        bus_rd(UART_RXD, d);
        exp_b = rxq[$];
        rxq.delete();
        chk("rxd_ovr", d, {24'h0, exp_b});
        bus_rd(UART_CON, d); chk("con_ovr_clr", d, 32'h02);
        @(negedge clk); rx = 1'b0;
        cyc(50);
        rx = 1'b1;
        cyc(400);
        bus_rd(UART_CON, d); chk("con_glitch", d, 32'h02);
        chk("irq_glitch", 32'(irq), 32'h0);

        // 6: framing error leaves the pending byte alone
        rxq.push_back(8'h44);
        send_rx(8'h44, 1'b1);
        send_rx(8'h33, 1'b0);
        bus_rd(UART_CON, d); chk("con_ferr", d, 32'h4A);
        bus_rd(UART_RXD, d);
        exp_b = rxq.pop_front();
        chk("rxd_after_ferr", d, {24'h0, exp_b});
        bus_rd(UART_CON, d); chk("con_ferr_clr", d, 32'h02);

        // register map edges
        bus_wr(UART_CON, 32'hFF);
        bus_rd(UART_CON, d); chk("con_ro_bits", d, 32'h03);
        bus_rd(8'h24, d); chk("unmapped_rd", d, 32'h0);
        @(negedge clk); addr = {24'h400000, UART_CON}; rd = 1'b0;
        #1 chk("rdata_no_rd", rdata, 32'h0);

        // reset mid-frame
        bus_wr(UART_TXD, 32'h00);
        wait_tx_low("tx2_start_seen");
        cyc(300);
        chk("tx_mid_low", 32'(tx), 32'h0);
        #2 reset = 1'b0;
        #1 chk("tx_async_high", 32'(tx), 32'h1);
        chk("irq_in_reset", 32'(irq), 32'h0);
        cyc(3);
        @(negedge clk); reset = 1'b1;
        bus_rd(UART_CON, d); chk("con_after_rst", d, 32'h0);
        bus_rd(UART_TXD, d); chk("txd_after_rst", d, 32'h0);
        cyc(200);
        chk("tx_idle_after_rst", 32'(tx), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
